mem_bus_sequencer: RTL and testbench

Multi-cycle memory-side sequencer for the MIPS core. It fetches each instruction and performs the load or store requested by `control_signals` over the single Avalon-style memory bus. It returns the end-of-instruction pulses (`end_of_inst_reg`, `end_of_inst_store`) that `control_signals` consumes. It waits for `fetch` before starting the next instruction and halts on a fetch from address 0.

---
 rtl/mem_bus_sequencer_if.sv | 25 ++
 rtl/mem_bus_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_mem_bus_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_sequencer_if.sv
// Avalon-style memory bus between the sequencer (master) and memory (slave).
// Word-wide bus with byte enables; readdata is valid in the accept cycle.
interface mem_bus_sequencer_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, waitrequest
    );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Memory-side sequencer for the MIPS core: instruction fetch plus one load or
// store per instruction over a single Avalon-style bus; halts on a fetch from 0.
module mem_bus_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [31:0]           pc,
    input  logic                  fetch,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [31:0]           mem_addr,
    input  logic [31:0]           store_data,
    output logic [31:0]           instr,
    output logic                  instr_valid,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  end_of_inst_reg,
    output logic                  end_of_inst_store,
    output logic                  active,
    output logic                  addr_err,
    mem_bus_sequencer_if.master   bus
);
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        LOAD,
        STORE,
        WAIT_FETCH,
        HALT
    } state_t;

    state_t              stateQ, stateD;
    logic [ADDR_W-1:0]   addressQ, addressD;
    logic                readQ, readD;
    logic                writeQ, writeD;
    logic [DATA_W-1:0]   writeDataQ, writeDataD;
    logic [BE_W-1:0]     byteEnQ, byteEnD;
    logic [DATA_W-1:0]   instrQ, instrD;
    logic                instrValidQ, instrValidD;
    logic [DATA_W-1:0]   loadDataQ, loadDataD;
    logic                loadValidQ, loadValidD;
    logic                eoiRegQ, eoiRegD;
    logic                eoiStoreQ, eoiStoreD;
    logic                activeQ, activeD;
    logic                addrErrQ, addrErrD;
    logic                accept;
    logic [ADDR_W-1:0]   memAddrAligned;
    logic                memAddrMisaligned;

    // Strobes are always high in FETCH/LOAD/STORE, so only the stall matters there.
    assign accept            = !bus.waitrequest;
    assign memAddrAligned    = {mem_addr[ADDR_W-1:2], 2'b00};
    assign memAddrMisaligned = (mem_addr[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateQ      <= IDLE;
            addressQ    <= '0;
            readQ       <= 1'b0;
            writeQ      <= 1'b0;
            writeDataQ  <= '0;
            byteEnQ     <= '0;
            instrQ      <= '0;
            instrValidQ <= 1'b0;
            loadDataQ   <= '0;
            loadValidQ  <= 1'b0;
            eoiRegQ     <= 1'b0;
            eoiStoreQ   <= 1'b0;
            activeQ     <= 1'b1;
            addrErrQ    <= 1'b0;
        end else begin
            stateQ      <= stateD;
            addressQ    <= addressD;
            readQ       <= readD;
            writeQ      <= writeD;
            writeDataQ  <= writeDataD;
            byteEnQ     <= byteEnD;
            instrQ      <= instrD;
            instrValidQ <= instrValidD;
            loadDataQ   <= loadDataD;
            loadValidQ  <= loadValidD;
            eoiRegQ     <= eoiRegD;
            eoiStoreQ   <= eoiStoreD;
            activeQ     <= activeD;
            addrErrQ    <= addrErrD;
        end
    end

    // Next state and next register values; bus fields only change on entry or accept.
    always_comb begin
        stateD      = stateQ;
        addressD    = addressQ;
        readD       = readQ;
        writeD      = writeQ;
        writeDataD  = writeDataQ;
        instrD      = instrQ;
        instrValidD = 1'b0;
        loadDataD   = loadDataQ;
        loadValidD  = 1'b0;
        eoiRegD     = 1'b0;
        eoiStoreD   = 1'b0;
        activeD     = activeQ;
        addrErrD    = addrErrQ;

        case (stateQ)
            IDLE: begin
                stateD   = FETCH;
                readD    = 1'b1;
                addressD = {RESET_VECTOR[ADDR_W-1:2], 2'b00};
            end
            FETCH: begin
                if (accept) begin
                    readD       = 1'b0;
                    instrD      = bus.readdata;
                    instrValidD = 1'b1;
                    stateD      = EXEC;
                end
            end
            EXEC: begin
                if (mem_read) begin
                    stateD   = LOAD;
                    readD    = 1'b1;
                    addressD = memAddrAligned;
                    if (mem_write || memAddrMisaligned) begin
                        addrErrD = 1'b1;
                    end
                end else if (mem_write) begin
                    stateD     = STORE;
                    writeD     = 1'b1;
                    addressD   = memAddrAligned;
                    writeDataD = store_data;
                    if (memAddrMisaligned) begin
                        addrErrD = 1'b1;
                    end
                end else begin
                    eoiRegD = 1'b1;
                    stateD  = WAIT_FETCH;
                end
            end
            LOAD: begin
                if (accept) begin
                    readD      = 1'b0;
                    loadDataD  = bus.readdata;
                    loadValidD = 1'b1;
                    eoiRegD    = 1'b1;
                    stateD     = WAIT_FETCH;
                end
            end
            STORE: begin
                if (accept) begin
                    writeD    = 1'b0;
                    eoiStoreD = 1'b1;
                    stateD    = WAIT_FETCH;
                end
            end
            WAIT_FETCH: begin
                if (fetch) begin
                    if (pc == '0) begin
                        stateD  = HALT;
                        activeD = 1'b0;
                    end else begin
                        stateD   = FETCH;
                        readD    = 1'b1;
                        addressD = {pc[ADDR_W-1:2], 2'b00};
                        if (pc[1:0] != 2'b00) begin
                            addrErrD = 1'b1;
                        end
                    end
                end
            end
            HALT: begin
                activeD = 1'b0;
                readD   = 1'b0;
                writeD  = 1'b0;
            end
            default: begin
                stateD = IDLE;
                readD  = 1'b0;
                writeD = 1'b0;
            end
        endcase

        byteEnD = (readD || writeD) ? {BE_W{1'b1}} : {BE_W{1'b0}};
    end

    assign bus.address        = addressQ;
    assign bus.read           = readQ;
    assign bus.write          = writeQ;
    assign bus.writedata      = writeDataQ;
    assign bus.byteenable     = byteEnQ;
    assign instr              = instrQ;
    assign instr_valid        = instrValidQ;
    assign load_data          = loadDataQ;
    assign load_valid         = loadValidQ;
    assign end_of_inst_reg    = eoiRegQ;
    assign end_of_inst_store  = eoiStoreQ;
    assign active             = activeQ;
    assign addr_err           = addrErrQ;
endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer with a small wait-state memory responder.
module tb_mem_bus_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc;
    logic        fetch;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] store_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] load_data;
    logic        load_valid;
    logic        end_of_inst_reg;
    logic        end_of_inst_store;
    logic        active;
    logic        addr_err;

    int checks = 0;
    int errors = 0;

    // Responder: data region below 1 MiB, everything else returns the instruction word.
    int          waitInstr = 0;
    int          waitData  = 0;
    int          wcnt      = 0;
    logic [31:0] curInstr  = 32'h0;
    logic [31:0] curLoad   = 32'h0;

    mem_bus_sequencer_if bus ();

    mem_bus_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .pc                (pc),
        .fetch             (fetch),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_addr          (mem_addr),
        .store_data        (store_data),
        .instr             (instr),
        .instr_valid       (instr_valid),
        .load_data         (load_data),
        .load_valid        (load_valid),
        .end_of_inst_reg   (end_of_inst_reg),
        .end_of_inst_store (end_of_inst_store),
        .active            (active),
        .addr_err          (addr_err),
        .bus               (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.read || bus.write) begin
            if (wcnt < ((bus.address < 32'h0010_0000) ? waitData : waitInstr)) begin
                bus.waitrequest = 1'b1;
                wcnt++;
            end else begin
                bus.waitrequest = 1'b0;
                wcnt = 0;
            end
        end else begin
            bus.waitrequest = 1'b0;
            wcnt = 0;
        end
        bus.readdata = (bus.address < 32'h0010_0000) ? curLoad : curInstr;
    end

    // Strobes must never overlap.
    always @(negedge clk) begin
        if (bus.read === 1'b1 || bus.write === 1'b1) begin
            checks++;
            if ({bus.read, bus.write} === 2'b11) begin
                errors++;
                $display("FAIL strobe_overlap: read=%b write=%b want not both 1", bus.read, bus.write);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; fetch = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        pc = 32'h0; mem_addr = 32'h0; store_data = 32'h0;
        tick(); tick();
        checks++;
        if ({bus.read, bus.write, bus.byteenable, bus.address, bus.writedata} !== 70'h0) begin
            errors++;
            $display("FAIL reset_bus: rd=%b wr=%b be=%h addr=%h wd=%h want all 0", bus.read, bus.write, bus.byteenable, bus.address, bus.writedata);
        end
        checks++;
        if ({instr_valid, load_valid, end_of_inst_reg, end_of_inst_store, active, addr_err} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000010", {instr_valid, load_valid, end_of_inst_reg, end_of_inst_store, active, addr_err});
        end
        checks++;
        if ({instr, load_data} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: instr=%h load_data=%h want 0", instr, load_data);
        end
    endtask

    task automatic test_alu();
        curInstr = 32'h0085_1021;
        reset_n = 1'b1;
        tick();
        checks++;
        if ({bus.read, bus.write, bus.address, bus.byteenable} !== {1'b1, 1'b0, 32'hBFC0_0000, 4'hF}) begin
            errors++;
            $display("FAIL alu_fetch: rd=%b wr=%b addr=%h be=%h want 1 0 bfc00000 f", bus.read, bus.write, bus.address, bus.byteenable);
        end
        tick();
        checks++;
        if ({bus.read, instr_valid, end_of_inst_reg, instr} !== {3'b010, 32'h0085_1021}) begin
            errors++;
            $display("FAIL alu_exec: rd=%b iv=%b eoi=%b instr=%h want 0 1 0 00851021", bus.read, instr_valid, end_of_inst_reg, instr);
        end
        tick();
        checks++;
        if ({instr_valid, end_of_inst_reg, end_of_inst_store, bus.read} !== 4'b0100) begin
            errors++;
            $display("FAIL alu_eoi: iv/eoi_reg/eoi_st/rd=%b want 0100", {instr_valid, end_of_inst_reg, end_of_inst_store, bus.read});
        end
        tick();
        checks++;
        if ({end_of_inst_reg, bus.read} !== 2'b00) begin
            errors++;
            $display("FAIL alu_park: eoi/rd=%b want 00", {end_of_inst_reg, bus.read});
        end
    endtask

    task automatic test_load_wait();
        pc = 32'h0040_0000; fetch = 1'b1; mem_read = 1'b1; mem_addr = 32'h0000_1004;
        curInstr = 32'h8C82_0004; curLoad = 32'hDEAD_BEEF; waitData = 2;
        tick();
        checks++;
        if ({bus.read, bus.address} !== {1'b1, 32'h0040_0000}) begin
            errors++;
            $display("FAIL load_fetch: rd=%b addr=%h want 1 00400000", bus.read, bus.address);
        end
        fetch = 1'b0;
        tick();
        checks++;
        if ({instr_valid, instr} !== {1'b1, 32'h8C82_0004}) begin
            errors++;
            $display("FAIL load_exec: iv=%b instr=%h want 1 8c820004", instr_valid, instr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({bus.read, bus.write, bus.address, load_valid, end_of_inst_reg} !== {2'b10, 32'h0000_1004, 2'b00}) begin
                errors++;
                $display("FAIL load_hold%0d: rd=%b wr=%b addr=%h lv=%b eoi=%b want 1 0 00001004 0 0", i, bus.read, bus.write, bus.address, load_valid, end_of_inst_reg);
            end
        end
        tick();
        checks++;
        if ({bus.read, load_valid, end_of_inst_reg, addr_err, load_data} !== {4'b0110, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL load_done: rd=%b lv=%b eoi=%b err=%b data=%h want 0 1 1 0 deadbeef", bus.read, load_valid, end_of_inst_reg, addr_err, load_data);
        end
        tick();
        checks++;
        if ({load_valid, end_of_inst_reg} !== 2'b00) begin
            errors++;
            $display("FAIL load_pulse: lv/eoi=%b want 00", {load_valid, end_of_inst_reg});
        end
        mem_read = 1'b0;
    endtask

    task automatic test_store();
        pc = 32'h0040_0004; fetch = 1'b1; mem_write = 1'b1; mem_addr = 32'h0000_2000;
        store_data = 32'h1234_5678; curInstr = 32'hAC82_0000; waitData = 1;
        tick();
        fetch = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            tick();
            store_data = 32'hFFFF_FFFF;
            checks++;
            if ({bus.read, bus.write, bus.address, bus.writedata, bus.byteenable} !== {2'b01, 32'h0000_2000, 32'h1234_5678, 4'hF}) begin
                errors++;
                $display("FAIL store_hold%0d: rd=%b wr=%b addr=%h wd=%h be=%h want 0 1 00002000 12345678 f", i, bus.read, bus.write, bus.address, bus.writedata, bus.byteenable);
            end
        end
        tick();
        checks++;
        if ({bus.write, bus.byteenable, end_of_inst_store, end_of_inst_reg} !== {1'b0, 4'h0, 2'b10}) begin
            errors++;
            $display("FAIL store_done: wr=%b be=%h eoi_st=%b eoi_reg=%b want 0 0 1 0", bus.write, bus.byteenable, end_of_inst_store, end_of_inst_reg);
        end
        tick();
        checks++;
        if ({end_of_inst_store, end_of_inst_reg} !== 2'b00) begin
            errors++;
            $display("FAIL store_pulse: eoi_st/eoi_reg=%b want 00", {end_of_inst_store, end_of_inst_reg});
        end
        mem_write = 1'b0;
    endtask

    task automatic test_misaligned();
        pc = 32'h0040_0008; fetch = 1'b1; mem_read = 1'b1; mem_addr = 32'h0000_1006;
        curInstr = 32'h8C82_0006; curLoad = 32'hCAFE_F00D; waitData = 0;
        tick();
        fetch = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.read, bus.address, addr_err} !== {1'b1, 32'h0000_1004, 1'b1}) begin
            errors++;
            $display("FAIL misalign_bus: rd=%b addr=%h err=%b want 1 00001004 1", bus.read, bus.address, addr_err);
        end
        tick();
        checks++;
        if ({load_valid, addr_err, load_data} !== {2'b11, 32'hCAFE_F00D}) begin
            errors++;
            $display("FAIL misalign_done: lv=%b err=%b data=%h want 1 1 cafef00d", load_valid, addr_err, load_data);
        end
        mem_read = 1'b0;
    endtask

    task automatic test_back_to_back();
        pc = 32'h0040_000C; fetch = 1'b1; curInstr = 32'h0000_0020;
        tick();
        checks++;
        if ({bus.read, bus.address} !== {1'b1, 32'h0040_000C}) begin
            errors++;
            $display("FAIL b2b_fetch0: rd=%b addr=%h want 1 0040000c", bus.read, bus.address);
        end
        tick();
        checks++;
        if ({bus.read, instr_valid} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_exec: rd/iv=%b want 01", {bus.read, instr_valid});
        end
        tick();
        checks++;
        if ({bus.read, end_of_inst_reg} !== 2'b01) begin
            errors++;
            $display("FAIL b2b_eoi: rd/eoi=%b want 01", {bus.read, end_of_inst_reg});
        end
        tick();
        checks++;
        if ({bus.read, bus.address, addr_err} !== {1'b1, 32'h0040_000C, 1'b1}) begin
            errors++;
            $display("FAIL b2b_fetch1: rd=%b addr=%h err=%b want 1 0040000c 1", bus.read, bus.address, addr_err);
        end
        fetch = 1'b0;
        tick();
        tick();
        checks++;
        if ({end_of_inst_reg, addr_err} !== 2'b11) begin
            errors++;
            $display("FAIL b2b_sticky: eoi/err=%b want 11", {end_of_inst_reg, addr_err});
        end
    endtask

    task automatic test_halt();
        pc = 32'h0; fetch = 1'b1;
        tick();
        checks++;
        if ({active, bus.read, bus.write} !== 3'b000) begin
            errors++;
            $display("FAIL halt_enter: active/rd/wr=%b want 000", {active, bus.read, bus.write});
        end
        pc = 32'h0040_0000;
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({active, bus.read, bus.write, bus.byteenable} !== 7'h0) begin
                errors++;
                $display("FAIL halt_idle%0d: active=%b rd=%b wr=%b be=%h want 0 0 0 0", i, active, bus.read, bus.write, bus.byteenable);
            end
        end
        fetch = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; mem_read = 1'b1; mem_addr = 32'h0000_1002;
        curInstr = 32'h8C82_0002; waitData = 5;
        tick();
        checks++;
        if ({active, bus.read, bus.address} !== {2'b11, 32'hBFC0_0000}) begin
            errors++;
            $display("FAIL rml_fetch: active=%b rd=%b addr=%h want 1 1 bfc00000", active, bus.read, bus.address);
        end
        tick();
        tick();
        checks++;
        if ({bus.read, bus.address, addr_err} !== {1'b1, 32'h0000_1000, 1'b1}) begin
            errors++;
            $display("FAIL rml_load: rd=%b addr=%h err=%b want 1 00001000 1", bus.read, bus.address, addr_err);
        end
        tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if ({bus.read, bus.write, bus.byteenable, bus.address, active, addr_err, instr_valid, load_valid, end_of_inst_reg, end_of_inst_store}
                !== {2'b00, 4'h0, 32'h0, 6'b100000}) begin
            errors++;
            $display("FAIL rml_reset: rd=%b wr=%b be=%h addr=%h flags=%b want 0 0 0 0 100000", bus.read, bus.write, bus.byteenable, bus.address,
                     {active, addr_err, instr_valid, load_valid, end_of_inst_reg, end_of_inst_store});
        end
        checks++;
        if ({instr, load_data} !== 64'h0) begin
            errors++;
            $display("FAIL rml_data: instr=%h load_data=%h want 0", instr, load_data);
        end
        mem_read = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if ({bus.read, bus.address} !== {1'b1, 32'hBFC0_0000}) begin
            errors++;
            $display("FAIL rml_refetch: rd=%b addr=%h want 1 bfc00000", bus.read, bus.address);
        end
    endtask

    initial begin
        bus.waitrequest = 1'b0;
        bus.readdata    = 32'h0;
        test_reset();
        test_alu();
        test_load_wait();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_halt();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
